// File: rtl/pwm_cmd_dispatch_if.sv
// Decoded UART command frame bus from uart_mult_byte_rx into the PWM command dispatcher.
interface pwm_cmd_dispatch_if;
    logic        recv_done;
    logic [7:0]  hs_pwm_ch;
    logic [7:0]  hs_ctrl_sta;
    logic [7:0]  duty_num;
    logic [16:0] pulse_dessert;
    logic [7:0]  pulse_num;
    logic [31:0] PAT;

    modport master (
        output recv_done, hs_pwm_ch, hs_ctrl_sta, duty_num, pulse_dessert, pulse_num, PAT
    );

    modport slave (
        input recv_done, hs_pwm_ch, hs_ctrl_sta, duty_num, pulse_dessert, pulse_num, PAT
    );
endinterface

// File: rtl/pwm_cmd_dispatch.sv
// Command stage between the UART frame decoder and the pattern_pwm channel bank:
// buffers one frame, safely stops the addressed channels, then loads their shadow registers.
module pwm_cmd_dispatch #(
    parameter int _CH_NUM    = 8,
    parameter int _PAT_WIDTH = 16,
    parameter int _TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    pwm_cmd_dispatch_if.slave              frame,
    input  logic [_CH_NUM-1:0]             pwm_busy,
    input  logic [_CH_NUM-1:0]             pwm_valid,
    output logic [_CH_NUM-1:0]             ch_pwm_en,
    output logic [8*_CH_NUM-1:0]           ch_duty_num,
    output logic [16*_CH_NUM-1:0]          ch_pulse_dessert,
    output logic [8*_CH_NUM-1:0]           ch_pulse_num,
    output logic [_PAT_WIDTH*_CH_NUM-1:0]  ch_PAT,
    output logic [_CH_NUM-1:0]             ch_done,
    output logic                           cmd_ack,
    output logic                           cmd_err,
    output logic                           cmd_ovf,
    output logic                           disp_busy
);

    localparam int TW = (_TIMEOUT > 2) ? $clog2(_TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(_TIMEOUT - 1);

    localparam logic [7:0] CODE_STOP  = 8'h00;
    localparam logic [7:0] CODE_START = 8'h01;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CHECK     = 2'd1;
    localparam logic [1:0] ST_STOP_WAIT = 2'd2;
    localparam logic [1:0] ST_LOAD      = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [TW-1:0]         cnt, cnt_nxt;

    logic                  buf_valid;
    logic [7:0]            buf_mask, buf_ctrl, buf_duty, buf_num;
    logic [16:0]           buf_dessert;
    logic [_PAT_WIDTH-1:0] buf_pat;

    logic [7:0]            w_mask, w_ctrl, w_duty, w_num;
    logic [16:0]           w_dessert;
    logic [_PAT_WIDTH-1:0] w_pat;
    logic [15:0]           w_dessert_sat;

    logic                  pop, load;
    logic                  ack_nxt, err_nxt;
    logic [_CH_NUM-1:0]    sel, valid_q, num_nz, fin;
    logic [_CH_NUM-1:0]    en_nxt, done_nxt;

    logic                  unused_bits;
    assign unused_bits = &{1'b0, frame.PAT, w_mask};

    assign pop           = (state == ST_IDLE) && buf_valid;
    assign sel           = w_mask[_CH_NUM-1:0];
    assign w_dessert_sat = w_dessert[16] ? 16'hFFFF : w_dessert[15:0];
    assign disp_busy     = (state != ST_IDLE);

    // A frame arriving while the buffer is still occupied (and not draining this edge) is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid   <= 1'b0;
            buf_mask    <= '0;
            buf_ctrl    <= '0;
            buf_duty    <= '0;
            buf_num     <= '0;
            buf_dessert <= '0;
            buf_pat     <= '0;
            cmd_ovf     <= 1'b0;
        end else begin
            cmd_ovf <= 1'b0;
            if (pop)
                buf_valid <= 1'b0;
            if (frame.recv_done) begin
                if (!buf_valid || pop) begin
                    buf_valid   <= 1'b1;
                    buf_mask    <= frame.hs_pwm_ch;
                    buf_ctrl    <= frame.hs_ctrl_sta;
                    buf_duty    <= frame.duty_num;
                    buf_num     <= frame.pulse_num;
                    buf_dessert <= frame.pulse_dessert;
                    buf_pat     <= frame.PAT[_PAT_WIDTH-1:0];
                end else begin
                    cmd_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        num_nz = '0;
        for (int i = 0; i < _CH_NUM; i++)
            num_nz[i] = |ch_pulse_num[8*i +: 8];
    end

    assign fin = pwm_valid & ~valid_q & ch_pwm_en & num_nz;

    // Finite-run completion is applied first so that a LOAD on the same edge overrides it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        en_nxt    = ch_pwm_en & ~fin;
        done_nxt  = ch_done | fin;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_valid)
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (((w_ctrl != CODE_STOP) && (w_ctrl != CODE_START)) || (sel == '0) ||
                    ((w_ctrl == CODE_START) && (w_duty == 8'd0))) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (w_ctrl == CODE_STOP) begin
                    en_nxt    = en_nxt & ~sel;
                    ack_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    en_nxt    = en_nxt & ~sel;
                    cnt_nxt   = '0;
                    state_nxt = ST_STOP_WAIT;
                end
            end
            ST_STOP_WAIT: begin
                if ((pwm_busy & sel) == '0) begin
                    state_nxt = ST_LOAD;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            ST_LOAD: begin
                load      = 1'b1;
                en_nxt    = en_nxt | sel;
                done_nxt  = done_nxt & ~sel;
                ack_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ch_pwm_en <= '0;
            ch_done   <= '0;
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
            valid_q   <= '0;
            w_mask    <= '0;
            w_ctrl    <= '0;
            w_duty    <= '0;
            w_num     <= '0;
            w_dessert <= '0;
            w_pat     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ch_pwm_en <= en_nxt;
            ch_done   <= done_nxt;
            cmd_ack   <= ack_nxt;
            cmd_err   <= err_nxt;
            valid_q   <= pwm_valid;
            if (pop) begin
                w_mask    <= buf_mask;
                w_ctrl    <= buf_ctrl;
                w_duty    <= buf_duty;
                w_num     <= buf_num;
                w_dessert <= buf_dessert;
                w_pat     <= buf_pat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_duty_num      <= '0;
            ch_pulse_dessert <= '0;
            ch_pulse_num     <= '0;
            ch_PAT           <= '0;
        end else if (load) begin
            for (int i = 0; i < _CH_NUM; i++) begin
                if (sel[i]) begin
                    ch_duty_num[8*i +: 8]               <= w_duty;
                    ch_pulse_dessert[16*i +: 16]        <= w_dessert_sat;
                    ch_pulse_num[8*i +: 8]              <= w_num;
                    ch_PAT[_PAT_WIDTH*i +: _PAT_WIDTH]  <= w_pat;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_cmd_dispatch.sv
// Scenario bench for pwm_cmd_dispatch: status pulses are scoreboarded, channel state is
// compared against a small reference model of enables, done flags and shadows.
module tb_pwm_cmd_dispatch;

    localparam int CH = 8;
    localparam int PW = 16;
    localparam int TO = 64;

    localparam logic [2:0] EV_ACK = 3'b001;
    localparam logic [2:0] EV_ERR = 3'b010;
    localparam logic [2:0] EV_OVF = 3'b100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_cmd_dispatch_if frame_bus();

    logic [CH-1:0]      pwm_busy, pwm_valid;
    logic [CH-1:0]      ch_pwm_en, ch_done;
    logic [8*CH-1:0]    ch_duty_num, ch_pulse_num;
    logic [16*CH-1:0]   ch_pulse_dessert;
    logic [PW*CH-1:0]   ch_PAT;
    logic               cmd_ack, cmd_err, cmd_ovf, disp_busy;

    pwm_cmd_dispatch #(._CH_NUM(CH), ._PAT_WIDTH(PW), ._TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame            (frame_bus),
        .pwm_busy         (pwm_busy),
        .pwm_valid        (pwm_valid),
        .ch_pwm_en        (ch_pwm_en),
        .ch_duty_num      (ch_duty_num),
        .ch_pulse_dessert (ch_pulse_dessert),
        .ch_pulse_num     (ch_pulse_num),
        .ch_PAT           (ch_PAT),
        .ch_done          (ch_done),
        .cmd_ack          (cmd_ack),
        .cmd_err          (cmd_err),
        .cmd_ovf          (cmd_ovf),
        .disp_busy        (disp_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q[$];

    logic [CH-1:0]    m_en, m_done;
    logic [8*CH-1:0]  m_duty, m_num;
    logic [16*CH-1:0] m_dessert;
    logic [PW*CH-1:0] m_pat;

    logic [2:0] mon_st, mon_exp;

    // Every status pulse seen must match the next expected event, in order, one cycle each.
    always @(negedge clk) begin
        mon_st = {cmd_ovf, cmd_err, cmd_ack};
        if (rst_n && mon_st != 3'b000) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL status_unexpected: got %b, expected none", mon_st);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_st !== mon_exp) begin
                    n_fail++;
                    $display("[TB] FAIL status_order: got %b, expected %b", mon_st, mon_exp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] mask, input logic [7:0] code, input logic [7:0] duty,
                              input logic [16:0] dessert, input logic [7:0] num, input logic [31:0] pat);
        @(negedge clk);
        frame_bus.hs_pwm_ch     = mask;
        frame_bus.hs_ctrl_sta   = code;
        frame_bus.duty_num      = duty;
        frame_bus.pulse_dessert = dessert;
        frame_bus.pulse_num     = num;
        frame_bus.PAT           = pat;
        frame_bus.recv_done     = 1'b1;
        @(negedge clk);
        frame_bus.recv_done     = 1'b0;
    endtask

    task automatic model_start(input logic [7:0] mask, input logic [7:0] duty, input logic [16:0] dessert,
                               input logic [7:0] num, input logic [31:0] pat);
        for (int i = 0; i < CH; i++) begin
            if (mask[i]) begin
                m_duty[8*i +: 8]     = duty;
                m_dessert[16*i +: 16] = dessert[16] ? 16'hFFFF : dessert[15:0];
                m_num[8*i +: 8]      = num;
                m_pat[PW*i +: PW]    = pat[PW-1:0];
                m_en[i]              = 1'b1;
                m_done[i]            = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_bus.recv_done = 1'b0;
        frame_bus.hs_pwm_ch = '0;
        frame_bus.hs_ctrl_sta = '0;
        frame_bus.duty_num = '0;
        frame_bus.pulse_dessert = '0;
        frame_bus.pulse_num = '0;
        frame_bus.PAT = '0;
        pwm_busy = '0;
        pwm_valid = '0;
        m_en = '0; m_done = '0; m_duty = '0; m_num = '0; m_dessert = '0; m_pat = '0;
        #12;
        n_tests++;
        if ({ch_pwm_en, ch_done, cmd_ack, cmd_err, cmd_ovf, disp_busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %h, expected 0",
                     {ch_pwm_en, ch_done, cmd_ack, cmd_err, cmd_ovf, disp_busy});
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_shadows: got %h, expected 0",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_start_single();
        exp_q.push_back(EV_ACK);
        send_frame(8'h01, 8'h01, 8'd50, 17'd50, 8'd0, 32'h1);
        cycles(2);
        n_tests++;
        if (ch_pwm_en !== 8'h00 || disp_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_e2: got en=%h busy=%b, expected en=00 busy=1", ch_pwm_en, disp_busy);
        end
        cycles(1);
        n_tests++;
        if (ch_pwm_en !== 8'h00 || cmd_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_e3: got en=%h ack=%b, expected en=00 ack=0", ch_pwm_en, cmd_ack);
        end
        cycles(1);
        model_start(8'h01, 8'd50, 17'd50, 8'd0, 32'h1);
        n_tests++;
        if ({ch_pwm_en, cmd_ack, disp_busy} !== {8'h01, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL start_e4: got en=%h ack=%b busy=%b, expected en=01 ack=1 busy=0",
                     ch_pwm_en, cmd_ack, disp_busy);
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== {m_duty, m_num, m_dessert, m_pat}) begin
            n_fail++;
            $display("[TB] FAIL start_shadows: got %h, expected %h",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT}, {m_duty, m_num, m_dessert, m_pat});
        end
    endtask

    task automatic test_busy_wait();
        exp_q.push_back(EV_ACK);
        send_frame(8'h02, 8'h01, 8'd20, 17'd40, 8'd0, 32'h2);
        cycles(4);
        model_start(8'h02, 8'd20, 17'd40, 8'd0, 32'h2);
        n_tests++;
        if (ch_pwm_en !== m_en) begin
            n_fail++;
            $display("[TB] FAIL busy_pre_en: got %h, expected %h", ch_pwm_en, m_en);
        end
        pwm_busy[1] = 1'b1;
        send_frame(8'h03, 8'h01, 8'd77, 17'd99, 8'd0, 32'hABCD_1234);
        cycles(2);
        m_en[1:0] = 2'b00;
        n_tests++;
        if (ch_pwm_en !== m_en) begin
            n_fail++;
            $display("[TB] FAIL busy_e2_en: got %h, expected %h", ch_pwm_en, m_en);
        end
        for (int k = 0; k < 9; k++) begin
            cycles(1);
            n_tests++;
            if (ch_pwm_en[1:0] !== 2'b00 || disp_busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL busy_hold: got en=%b busy=%b, expected en=00 busy=1",
                         ch_pwm_en[1:0], disp_busy);
            end
        end
        cycles(1);
        exp_q.push_back(EV_ACK);
        pwm_busy[1] = 1'b0;
        cycles(1);
        n_tests++;
        if (ch_pwm_en[1:0] !== 2'b00 || disp_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_load_cycle: got en=%b busy=%b, expected en=00 busy=1",
                     ch_pwm_en[1:0], disp_busy);
        end
        cycles(1);
        model_start(8'h03, 8'd77, 17'd99, 8'd0, 32'hABCD_1234);
        n_tests++;
        if ({ch_pwm_en, ch_done} !== {m_en, m_done}) begin
            n_fail++;
            $display("[TB] FAIL busy_loaded_en: got %h, expected %h", {ch_pwm_en, ch_done}, {m_en, m_done});
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== {m_duty, m_num, m_dessert, m_pat}) begin
            n_fail++;
            $display("[TB] FAIL busy_shadows: got %h, expected %h",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT}, {m_duty, m_num, m_dessert, m_pat});
        end
    endtask

    task automatic test_timeout();
        pwm_busy[2] = 1'b1;
        exp_q.push_back(EV_ERR);
        send_frame(8'h04, 8'h01, 8'd9, 17'd9, 8'd1, 32'h9);
        cycles(2);
        n_tests++;
        if (ch_pwm_en !== m_en) begin
            n_fail++;
            $display("[TB] FAIL timeout_e2_en: got %h, expected %h", ch_pwm_en, m_en);
        end
        cycles(TO - 1);
        n_tests++;
        if (cmd_err !== 1'b0 || disp_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: got err=%b busy=%b, expected err=0 busy=1", cmd_err, disp_busy);
        end
        cycles(1);
        n_tests++;
        if (cmd_err !== 1'b1 || disp_busy !== 1'b0 || ch_pwm_en !== m_en) begin
            n_fail++;
            $display("[TB] FAIL timeout_err: got err=%b busy=%b en=%h, expected err=1 busy=0 en=%h",
                     cmd_err, disp_busy, ch_pwm_en, m_en);
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== {m_duty, m_num, m_dessert, m_pat}) begin
            n_fail++;
            $display("[TB] FAIL timeout_shadows: got %h, expected %h",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT}, {m_duty, m_num, m_dessert, m_pat});
        end
        pwm_busy[2] = 1'b0;
    endtask

    task automatic test_errors();
        logic [7:0] err_mask[3];
        logic [7:0] err_code[3];
        logic [7:0] err_duty[3];
        err_mask = '{8'h01, 8'h01, 8'h00};
        err_code = '{8'h01, 8'h07, 8'h01};
        err_duty = '{8'd0,  8'd9,  8'd9};
        exp_q.push_back(EV_ACK);
        send_frame(8'h08, 8'h01, 8'd5, 17'h1_0005, 8'd2, 32'h1234_5678);
        cycles(4);
        model_start(8'h08, 8'd5, 17'h1_0005, 8'd2, 32'h1234_5678);
        n_tests++;
        if (ch_pulse_dessert[16*3 +: 16] !== 16'hFFFF || ch_PAT[PW*3 +: PW] !== 16'h5678) begin
            n_fail++;
            $display("[TB] FAIL sat_dessert: got dessert=%h pat=%h, expected dessert=ffff pat=5678",
                     ch_pulse_dessert[16*3 +: 16], ch_PAT[PW*3 +: PW]);
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(EV_ERR);
            send_frame(err_mask[k], err_code[k], err_duty[k], 17'd7, 8'd7, 32'h77);
            cycles(2);
            n_tests++;
            if (cmd_err !== 1'b1 || disp_busy !== 1'b0 || {ch_pwm_en, ch_done} !== {m_en, m_done}) begin
                n_fail++;
                $display("[TB] FAIL err_case%0d: got err=%b busy=%b en/done=%h, expected err=1 busy=0 en/done=%h",
                         k, cmd_err, disp_busy, {ch_pwm_en, ch_done}, {m_en, m_done});
            end
            n_tests++;
            if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== {m_duty, m_num, m_dessert, m_pat}) begin
                n_fail++;
                $display("[TB] FAIL err_shadows%0d: got %h, expected %h", k,
                         {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT}, {m_duty, m_num, m_dessert, m_pat});
            end
        end
    endtask

    task automatic test_stop();
        exp_q.push_back(EV_ACK);
        send_frame(8'h01, 8'h00, 8'd0, 17'd0, 8'd0, 32'h0);
        cycles(2);
        m_en[0] = 1'b0;
        n_tests++;
        if (cmd_ack !== 1'b1 || disp_busy !== 1'b0 || ch_pwm_en !== m_en) begin
            n_fail++;
            $display("[TB] FAIL stop_ack: got ack=%b busy=%b en=%h, expected ack=1 busy=0 en=%h",
                     cmd_ack, disp_busy, ch_pwm_en, m_en);
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== {m_duty, m_num, m_dessert, m_pat}) begin
            n_fail++;
            $display("[TB] FAIL stop_shadows: got %h, expected %h",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT}, {m_duty, m_num, m_dessert, m_pat});
        end
    endtask

    task automatic test_finite_run();
        exp_q.push_back(EV_ACK);
        send_frame(8'h04, 8'h01, 8'd10, 17'd3, 8'd3, 32'h7);
        cycles(4);
        model_start(8'h04, 8'd10, 17'd3, 8'd3, 32'h7);
        n_tests++;
        if ({ch_pwm_en, ch_done} !== {m_en, m_done}) begin
            n_fail++;
            $display("[TB] FAIL finite_start: got %h, expected %h", {ch_pwm_en, ch_done}, {m_en, m_done});
        end
        // ch1 runs with pulse_num 0, so its valid must be ignored while ch2 completes
        pwm_valid[2] = 1'b1;
        pwm_valid[1] = 1'b1;
        cycles(1);
        m_en[2]   = 1'b0;
        m_done[2] = 1'b1;
        n_tests++;
        if ({ch_pwm_en, ch_done} !== {m_en, m_done}) begin
            n_fail++;
            $display("[TB] FAIL finite_done: got %h, expected %h", {ch_pwm_en, ch_done}, {m_en, m_done});
        end
        pwm_valid = '0;
        cycles(5);
        n_tests++;
        if ({ch_pwm_en, ch_done} !== {m_en, m_done}) begin
            n_fail++;
            $display("[TB] FAIL finite_sticky: got %h, expected %h", {ch_pwm_en, ch_done}, {m_en, m_done});
        end
        exp_q.push_back(EV_ACK);
        send_frame(8'h04, 8'h01, 8'd11, 17'd5, 8'd3, 32'h8);
        cycles(4);
        model_start(8'h04, 8'd11, 17'd5, 8'd3, 32'h8);
        n_tests++;
        if ({ch_pwm_en, ch_done} !== {m_en, m_done}) begin
            n_fail++;
            $display("[TB] FAIL finite_restart: got %h, expected %h", {ch_pwm_en, ch_done}, {m_en, m_done});
        end
    endtask

    task automatic test_back_to_back();
        pwm_busy[4] = 1'b1;
        send_frame(8'h10, 8'h01, 8'd44, 17'd21, 8'd0, 32'hA);
        cycles(2);
        frame_bus.hs_pwm_ch = 8'h02; frame_bus.hs_ctrl_sta = 8'h00; frame_bus.duty_num = 8'd0;
        frame_bus.recv_done = 1'b1;
        @(negedge clk);
        frame_bus.hs_pwm_ch = 8'h20; frame_bus.hs_ctrl_sta = 8'h01; frame_bus.duty_num = 8'd33;
        exp_q.push_back(EV_OVF);
        @(negedge clk);
        frame_bus.recv_done = 1'b0;
        n_tests++;
        if (cmd_ovf !== 1'b1 || disp_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_ovf: got ovf=%b busy=%b, expected ovf=1 busy=1", cmd_ovf, disp_busy);
        end
        exp_q.push_back(EV_ACK);
        exp_q.push_back(EV_ACK);
        pwm_busy[4] = 1'b0;
        cycles(2);
        model_start(8'h10, 8'd44, 17'd21, 8'd0, 32'hA);
        n_tests++;
        if (ch_pwm_en !== m_en || cmd_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got en=%h ack=%b, expected en=%h ack=1", ch_pwm_en, cmd_ack, m_en);
        end
        cycles(2);
        m_en[1] = 1'b0;
        n_tests++;
        if (ch_pwm_en !== m_en || cmd_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got en=%h ack=%b, expected en=%h ack=1", ch_pwm_en, cmd_ack, m_en);
        end
        cycles(6);
        n_tests++;
        if (ch_pwm_en !== m_en || disp_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_dropped: got en=%h busy=%b, expected en=%h busy=0", ch_pwm_en, disp_busy, m_en);
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== {m_duty, m_num, m_dessert, m_pat}) begin
            n_fail++;
            $display("[TB] FAIL b2b_shadows: got %h, expected %h",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT}, {m_duty, m_num, m_dessert, m_pat});
        end

        pwm_busy[6] = 1'b1;
        send_frame(8'h40, 8'h01, 8'd60, 17'd6, 8'd0, 32'h6);
        cycles(3);
        n_tests++;
        if (disp_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_pre_busy: got %b, expected 1", disp_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ch_pwm_en, ch_done, cmd_ack, cmd_err, cmd_ovf, disp_busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_ctrl: got %h, expected 0",
                     {ch_pwm_en, ch_done, cmd_ack, cmd_err, cmd_ovf, disp_busy});
        end
        n_tests++;
        if ({ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT} !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_shadows: got %h, expected 0",
                     {ch_duty_num, ch_pulse_num, ch_pulse_dessert, ch_PAT});
        end
        m_en = '0; m_done = '0; m_duty = '0; m_num = '0; m_dessert = '0; m_pat = '0;
        pwm_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL status_missing: got %0d pending events, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_start_single();
        test_busy_wait();
        test_timeout();
        test_errors();
        test_stop();
        test_finite_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
